// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared sizes and loader state type for the instruction-memory loader
package imem_pkg;

    localparam int IMEM_DEPTH = 64;
    localparam int IMEM_AW    = 6;
    localparam int IMEM_DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } imem_state_t;

endpackage

// File: rtl/imem_word_counter.sv
// rtl/imem_word_counter.sv - word address counter with clear/load, saturating increment and terminal count
module imem_word_counter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ADDR_W-1:0] last_in,
    input  logic              inc,
    output logic [ADDR_W-1:0] value,
    output logic              tc
);

    logic [ADDR_W-1:0] last;

    // Increment stops at the terminal value, so a full-depth load never wraps back to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
            last  <= '0;
        end else if (clear) begin
            value <= '0;
            last  <= last_in;
        end else if (inc && !tc) begin
            value <= value + 1'b1;
        end
    end

    assign tc = (value == last);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams words into instruction memory while holding the core; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DW,
    parameter int ADDR_W = IMEM_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] exp_sum,
    output logic [DATA_W-1:0] sum,
`endif
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    imem_state_t       state;
    logic              count_ok;
    logic              accept;
    logic              hs;
    logic [ADDR_W-1:0] cnt_value;
    logic              cnt_tc;

    assign count_ok = (count != '0) && (count <= MAX_COUNT);
    assign accept   = (state == ST_IDLE) && start && count_ok;
    assign hs       = in_valid && in_ready;

    // Terminal value is count-1; a count of 2**ADDR_W truncates to 0 and underflows to the top address.
    imem_word_counter #(
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .last_in (count[ADDR_W-1:0] - 1'b1),
        .inc     (hs),
        .value   (cnt_value),
        .tc      (cnt_tc)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] exp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            exp_q <= '0;
        end else if (accept) begin
            acc   <= '0;
            exp_q <= exp_sum;
        end else if (hs) begin
            acc   <= acc + in_data;
        end
    end

    assign sum = acc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            we   <= hs;
            done <= 1'b0;
            err  <= 1'b0;
            if (hs) begin
                waddr <= cnt_value;
                wdata <= in_data;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count_ok) begin
                            state     <= ST_LOAD;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                            core_hold <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (hs && cnt_tc) begin
                        state    <= ST_FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    err   <= (acc != exp_q);
`endif
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    core_hold <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [AW:0]   count    = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready, we, core_hold, busy, done, err;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] exp_sum = '0;
    logic [DW-1:0] sum;
`endif

    always #5 clk = ~clk;

    imem_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .exp_sum   (exp_sum),
        .sum       (sum),
`endif
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int done_n = 0, err_n = 0, busy_n = 0, hold_n = 0, hold_bad = 0;
    int done_cyc = -1, err_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (we) begin
            wa_q.push_back(int'(waddr));
            wd_q.push_back(wdata);
            wc_q.push_back(cyc);
        end
        if (done) begin done_n++; done_cyc = cyc; end
        if (err) begin err_n++; err_cyc = cyc; end
        if (busy) busy_n++;
        if (core_hold) hold_n++;
        if ((we || done) && !core_hold) hold_bad++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_n = 0; err_n = 0; busy_n = 0; hold_n = 0; hold_bad = 0;
        done_cyc = -1; err_cyc = -1;
    endtask

    task automatic start_load(input int c, input logic [31:0] esum);
        start = 1'b1;
        count = c[AW:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_sum = esum;
`else
        if (esum == 32'h0) in_data = '0;
`endif
        tick();
        start = 1'b0;
    endtask

    task automatic drive_words(input logic [31:0] words[$], input int n, input int gap, output int taken);
        int guard;
        logic v;
        taken = 0;
        guard = 0;
        while (taken < n && guard < 2000) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? words[taken] : $urandom;
            if (v && in_ready) taken++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (done_n == 0 && k < limit) begin
            tick();
            k++;
        end
        tick();
    endtask

    // Reference: a legal load of n words yields exactly writes (i, words[i]) for i = 0..n-1.
    task automatic check_writes(input string tag, input logic [31:0] words[$], input int n);
        check({tag, "_nwrites"}, wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wd_q[i], words[i]);
        end
    endtask

    typedef struct {
        int cnt;
        int gap;
        bit rej;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] words[$];
        logic [31:0] msum;
        int n, taken;
        n = v.rej ? 4 : v.cnt;
        msum = '0;
        for (int i = 0; i < n; i++) begin
            words.push_back($urandom);
            msum = msum + words[i];
        end
        clear_mon();
        start_load(v.cnt, msum);
        if (v.rej) begin
            check({tag, "_err_next"}, err, 1);
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_data  = words[i];
                tick();
            end
            in_valid = 1'b0;
            tick();
            tick();
            check({tag, "_err_n"}, err_n, 1);
            check({tag, "_busy_n"}, busy_n, 0);
            check({tag, "_done_n"}, done_n, 0);
            check({tag, "_nwrites"}, wa_q.size(), 0);
        end else begin
            drive_words(words, n, v.gap, taken);
            check({tag, "_taken"}, taken, n);
            wait_done(20);
            check({tag, "_done_n"}, done_n, 1);
            check({tag, "_err_n"}, err_n, 0);
            check_writes(tag, words, n);
            check({tag, "_hold_bad"}, hold_bad, 0);
            check({tag, "_hold_eq_busy"}, hold_n, busy_n);
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_idle_hold"}, core_hold, 0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] w[$];
        int taken;

        vecs[0] = '{cnt: 0,   gap: 0, rej: 1'b1};
        vecs[1] = '{cnt: 65,  gap: 0, rej: 1'b1};
        vecs[2] = '{cnt: 127, gap: 0, rej: 1'b1};
        vecs[3] = '{cnt: 1,   gap: 0, rej: 1'b0};
        vecs[4] = '{cnt: 2,   gap: 2, rej: 1'b0};
        vecs[5] = '{cnt: 64,  gap: 1, rej: 1'b0};
        vecs[6] = '{cnt: 3,   gap: 2, rej: 1'b0};
        vecs[7] = '{cnt: 17,  gap: 2, rej: 1'b0};

        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_core_hold", core_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        tick();

        // Back-to-back three-word load: consecutive writes, done right after the flush cycle.
        w = '{32'h20020005, 32'h2003000C, 32'h2067FFF7};
        clear_mon();
        start_load(3, 32'h4206FFF0 + 32'h0);
        drive_words(w, 3, 0, taken);
        wait_done(20);
        check_writes("b2b", w, 3);
        if (wc_q.size() == 3) begin
            check("b2b_consec1", wc_q[1], wc_q[0] + 1);
            check("b2b_consec2", wc_q[2], wc_q[0] + 2);
            check("b2b_done_cyc", done_cyc, wc_q[2] + 1);
        end
        check("b2b_hold_cycles", hold_n, 5);
        check("b2b_hold_bad", hold_bad, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("b2b_err_n", err_n, 0);
`endif

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 6; i++) begin
            vec_t rv;
            rv.cnt = $urandom_range(1, 64);
            rv.gap = 2;
            rv.rej = 1'b0;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a four-word load, then a fresh one-word load.
        clear_mon();
        start_load(4, 32'h0);
        in_valid = 1'b1;
        in_data  = 32'hA5A50001;
        tick();
        in_data  = 32'hA5A50002;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_we", we, 0);
        check("mid_rst_waddr", waddr, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_hold", core_hold, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        w = '{32'hCAFEF00D};
        clear_mon();
        start_load(1, 32'hCAFEF00D);
        drive_words(w, 1, 0, taken);
        wait_done(20);
        check_writes("after_rst", w, 1);
        check("after_rst_done_n", done_n, 1);

        // A second start during LOAD must not change the original count.
        w = '{32'h11110000, 32'h22220000};
        clear_mon();
        start_load(2, 32'h33330000);
        start    = 1'b1;
        count    = 7'd5;
        in_valid = 1'b1;
        in_data  = w[0];
        tick();
        start    = 1'b0;
        in_data  = w[1];
        tick();
        in_valid = 1'b0;
        wait_done(20);
        check_writes("restart", w, 2);
        check("restart_err_n", err_n, 0);
        check("restart_done_n", done_n, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        w = '{32'h1, 32'h2};
        clear_mon();
        start_load(2, 32'h3);
        drive_words(w, 2, 0, taken);
        wait_done(20);
        check("cks_ok_done_n", done_n, 1);
        check("cks_ok_err_n", err_n, 0);
        check("cks_ok_sum", sum, 32'h3);
        clear_mon();
        start_load(2, 32'h4);
        drive_words(w, 2, 0, taken);
        wait_done(20);
        check("cks_bad_done_n", done_n, 1);
        check("cks_bad_err_n", err_n, 1);
        check("cks_bad_err_with_done", err_cyc, done_cyc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 6, word address width; depth = 2**ADDR_W (64).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port count  input  ADDR_W+1  words to load; legal 1..64; sampled with start.
REQ-007 SHALL have port in_valid  input  1  source word valid.
REQ-008 SHALL have port in_data  input  DATA_W  source instruction word.
REQ-009 SHALL have port in_ready  output  1  loader accepts word this cycle.
REQ-010 SHALL have port we  output  1  instruction-memory write enable.
REQ-011 SHALL have port waddr  output  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port wdata  output  DATA_W  instruction-memory write data.
REQ-013 SHALL have port core_hold  output  1  holds core PC register (drives stallF) while loading.
REQ-014 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-015 SHALL have port done  output  1  one-cycle pulse when load completes.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected start or checksum mismatch.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-018 IDLE: start with count in 1..64 SHALL latch count, clear address counter to 0, go to LOAD.
REQ-019 IDLE: start with count 0 or >64 SHALL pulse err next cycle and remain IDLE.
REQ-020 LOAD: in_ready SHALL be 1; handshake = in_valid & in_ready.
REQ-021 Each handshake SHALL register we=1, waddr=counter, wdata=in_data on the next edge (latency 1), then increment counter.
REQ-022 we SHALL be 0 in every cycle without a preceding-cycle handshake; waddr/wdata hold last value.
REQ-023 Handshake on word count-1 SHALL transition to FLUSH; in_ready SHALL be 0 outside LOAD.
REQ-024 FLUSH SHALL last one cycle (final write visible), then DONE; DONE SHALL pulse done and return to IDLE.
REQ-025 core_hold SHALL be 1 from the cycle after an accepted start through the DONE cycle inclusive.
REQ-026 start while busy SHALL be ignored without err.
REQ-027 Counter SHALL never exceed count-1; count=64 SHALL write addresses 0..63 with no wrap to 0.
REQ-028 in_valid in IDLE SHALL be ignored (no write, no err).

Reset
REQ-029 reset low SHALL immediately force IDLE, counter 0, and in_ready, we, waddr, wdata, core_hold, busy, done, err all 0.
REQ-030 Reset mid-LOAD SHALL abandon the load; partially written words are not reverted.

Configuration
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, SHALL add input exp_sum (DATA_W) sampled with start and output sum (DATA_W); accumulate modulo-2**DATA_W sum of accepted words; in DONE, mismatch SHALL pulse err together with done.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, exp_sum/sum ports and accumulator SHALL not exist; err only from REQ-019.

Structure
REQ-033 Shared package imem_pkg SHALL hold IMEM_DEPTH=64, IMEM_AW=6, IMEM_DW=32 and the state enum type.
REQ-034 Address counter with load/clear/increment/terminal-count SHALL be sub-module imem_word_counter.

Verification
REQ-035 reset low, start=1 count=3, words 0x20020005,0x2003000C,0x2067FFF7 back-to-back -> we at addr 0,1,2 on consecutive cycles, done pulse, core_hold high throughout.
REQ-036 count=64, in_valid toggling every other cycle -> 64 writes, last waddr=63, no write to 0 after 63.
REQ-037 start with count=0 and with count=65 -> err pulse each, busy stays 0, no we.
REQ-038 count=4, assert reset low after 2nd word -> all outputs 0 immediately; new start count=1 completes normally.
REQ-039 start pulsed again during LOAD with count=2 -> ignored, original count honoured, no err.
REQ-040 With IMEM_LOADER_CHECKSUM_EN: count=2, words 0x1,0x2, exp_sum=0x3 -> done without err; exp_sum=0x4 -> done with err.
